// File: rtl/display_scheduler.sv
// display_scheduler
//   Shares a 3-digit multiplexed 7-segment display between two requesters.
//   A round-robin arbiter grants one requester and captures its 8-bit value.
//   A sequential double-dabble converter (8 iterations) turns it into BCD,
//   which is then held on the display for HOLD_TICKS cycles before the
//   arbiter looks at the requests again. A free-running scan counter walks
//   the three digits, REFRESH_TICKS cycles per digit.
//
//   Handshake: ReqA/ReqB are level requests sampled only in IDLE. The
//   matching GntA/GntB is a one-cycle pulse in the cycle after the grant
//   edge, and the Data of the granted port is captured on that same edge.
//   Requests seen outside IDLE are ignored, not queued.
//
// Ports
//   Clk, Rst        clock, asynchronous active-high reset
//   ReqA, DataA     requester A level request and 8-bit value
//   ReqB, DataB     requester B level request and 8-bit value
//   GntA, GntB      one-cycle grant pulses
//   Busy            high while converting or holding
//   Displays        active-low anode enables (bits 7:3 always 1)
//   Segmentos       active-low segments {dp,g,f,e,d,c,b,a}
module display_scheduler #(
  parameter int unsigned REFRESH_TICKS = 100000,
  parameter int unsigned HOLD_TICKS    = 50000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ReqA,
  input  logic [7:0] DataA,
  input  logic       ReqB,
  input  logic [7:0] DataB,
  output logic       GntA,
  output logic       GntB,
  output logic       Busy,
  output logic [7:0] Displays,
  output logic [7:0] Segmentos
);

  localparam int unsigned SCAN_W = $clog2(REFRESH_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  // state_q is the FSM state for observers; nothing else encodes it.
  state_t            state_q, state_next;
  logic              grant_a, grant_b;
  logic              rr_b;              // 1: favour B on the next tie
  logic [7:0]        bin_q;
  logic [11:0]       bcd_q;
  logic [11:0]       bcd_adj, bcd_nx;
  logic [7:0]        bin_nx;
  logic [2:0]        iter_q;
  logic [HOLD_W-1:0] hold_q;
  logic [3:0]        hun_q, ten_q, one_q;
  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        sel_q;
  logic [3:0]        digit;
  logic              blank;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // FSM next state, including the arbitration decision made in IDLE
  always_comb begin
    state_next = state_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqA && ReqB) begin
          grant_a = ~rr_b;
          grant_b = rr_b;
        end else begin
          grant_a = ReqA;
          grant_b = ReqB;
        end
        if (grant_a || grant_b) state_next = CONVERT;
      end
      CONVERT: if (iter_q == 3'd7) state_next = SHOW;
      SHOW:    if (hold_q == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (state_q != IDLE);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift left by one
  // with the binary MSB entering the BCD LSB.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_adj[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_adj[3:0]  + 4'd3;
    if (bcd_adj[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_adj[7:4]  + 4'd3;
    if (bcd_adj[11:8] >= 4'd5) bcd_adj[11:8] = bcd_adj[11:8] + 4'd3;
    bcd_nx = {bcd_adj[10:0], bin_q[7]};
    bin_nx = {bin_q[6:0], 1'b0};
  end

  // Grant pulses, capture, conversion and hold datapath
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      GntA   <= 1'b0;
      GntB   <= 1'b0;
      rr_b   <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      hold_q <= '0;
      hun_q  <= '0;
      ten_q  <= '0;
      one_q  <= '0;
    end else begin
      GntA <= grant_a;
      GntB <= grant_b;
      if (grant_a || grant_b) begin
        // The pointer only moves on a tie; a lone requester leaves it alone.
        if (ReqA && ReqB) rr_b <= ~rr_b;
        bin_q  <= grant_a ? DataA : DataB;
        bcd_q  <= '0;
        iter_q <= '0;
      end
      if (state_q == CONVERT) begin
        bcd_q  <= bcd_nx;
        bin_q  <= bin_nx;
        iter_q <= iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          hun_q  <= bcd_nx[11:8];
          ten_q  <= bcd_nx[7:4];
          one_q  <= bcd_nx[3:0];
          hold_q <= '0;
        end
      end
      if (state_q == SHOW && hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
    end
  end

  // Free-running digit scan, independent of the FSM
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scan_q <= '0;
      sel_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      sel_q  <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Anode/segment decode from registered select and digits only, so a
  // digit change and a select change can never be seen out of step.
  always_comb begin
    Displays = 8'hFF;
    digit    = one_q;
    blank    = 1'b1;
    case (sel_q)
      2'd0: begin Displays = 8'hFE; digit = one_q; blank = 1'b0; end
      2'd1: begin Displays = 8'hFD; digit = ten_q; blank = (hun_q == 4'd0) && (ten_q == 4'd0); end
      2'd2: begin Displays = 8'hFB; digit = hun_q; blank = (hun_q == 4'd0); end
      default: begin Displays = 8'hFF; digit = one_q; blank = 1'b1; end
    endcase
    Segmentos = blank ? 8'hFF : seg_code(digit);
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with REFRESH_TICKS = 4, HOLD_TICKS = 10.
// Inputs are driven and outputs sampled on the falling clock edge.
// Cycle index k counts falling edges after the grant edge (k = 0 is the
// first sample after the grant): Gnt is high at k = 0, new digits appear at
// k = 8, Busy is high through k = 17 and low from k = 18.
module tb_display_scheduler;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, busy;
  logic [7:0] displays, segmentos;

  int tests_run = 0;
  int fails     = 0;
  logic [7:0] exp_q[$];

  display_scheduler #(.REFRESH_TICKS(4), .HOLD_TICKS(10)) dut (
    .Clk(clk), .Rst(rst),
    .ReqA(req_a), .DataA(data_a),
    .ReqB(req_b), .DataB(data_b),
    .GntA(gnt_a), .GntB(gnt_b), .Busy(busy),
    .Displays(displays), .Segmentos(segmentos)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Checks the segment pattern of whichever digit is currently selected
  // against hand-computed codes for hundreds/tens/ones.
  task automatic chk_seg(input string tag, input logic [7:0] h, input logic [7:0] t,
                         input logic [7:0] o);
    case (displays)
      8'hFE:   chk8({tag, "_ones"}, segmentos, o);
      8'hFD:   chk8({tag, "_tens"}, segmentos, t);
      8'hFB:   chk8({tag, "_hund"}, segmentos, h);
      default: chk8({tag, "_anode"}, displays, 8'hFE);
    endcase
  endtask

  task automatic grant_a_value(input logic [7:0] v);
    req_a  = 1'b1;
    data_a = v;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk1("rst_gnt_a", gnt_a, 1'b0);
    chk1("rst_gnt_b", gnt_b, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_disp", displays, 8'hFE);
    chk8("rst_seg", segmentos, 8'hC0);

    // ---- idle scan: FE x4, FD x4, FB x4, repeating; 0 shown as blank/blank/0
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      case ((k / 4) % 3)
        0: begin chk8("scan_disp", displays, 8'hFE); chk8("scan_seg", segmentos, 8'hC0); end
        1: begin chk8("scan_disp", displays, 8'hFD); chk8("scan_seg", segmentos, 8'hFF); end
        default: begin chk8("scan_disp", displays, 8'hFB); chk8("scan_seg", segmentos, 8'hFF); end
      endcase
      chk1("scan_busy", busy, 1'b0);
      @(negedge clk);
    end

    // ---- single request A = 0xA9 (169)
    grant_a_value(8'hA9);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      chk1("a9_gnt_a", gnt_a, k == 0);
      chk1("a9_gnt_b", gnt_b, 1'b0);
      chk1("a9_busy", busy, k < 18);
      if (k == 0) begin
        req_a  = 1'b0;
        data_a = 8'h00;   // changing data after the grant has no effect
      end
      if (k == 7) chk_seg("a9_old", 8'hFF, 8'hFF, 8'hC0);
      if (k >= 8) chk_seg("a9", 8'hF9, 8'h82, 8'h90);
    end

    // ---- both requesting: A(0x04), B(0xFF), A in that order
    req_a = 1'b1; data_a = 8'h04;
    req_b = 1'b1; data_b = 8'hFF;
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h0A);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk1("rr_gnt_a", gnt_a, (k == 0) || (k == 38));
      chk1("rr_gnt_b", gnt_b, k == 19);
      if (gnt_a || gnt_b) begin
        if (exp_q.size() == 0) chk8("rr_extra_grant", gnt_a ? 8'h0A : 8'h0B, 8'h00);
        else chk8("rr_order", gnt_a ? 8'h0A : 8'h0B, exp_q.pop_front());
      end
      if (k == 40) begin req_a = 1'b0; req_b = 1'b0; end
      if (k >= 8 && k < 27)  chk_seg("rr_a4", 8'hFF, 8'hFF, 8'h99);
      if (k >= 27 && k < 46) chk_seg("rr_b255", 8'hA4, 8'h92, 8'h92);
      if (k >= 46)           chk_seg("rr_a4_again", 8'hFF, 8'hFF, 8'h99);
    end
    chk8("rr_grants_left", 8'(exp_q.size()), 8'd0);

    // ---- B pulses during A's conversion: ignored, not queued
    grant_a_value(8'h2A);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk1("late_gnt_a", gnt_a, k == 0);
      chk1("late_gnt_b", gnt_b, 1'b0);
      chk1("late_busy", busy, k < 18);
      if (k == 0) req_a = 1'b0;
      if (k == 2) begin req_b = 1'b1; data_b = 8'h11; end
      if (k == 5) req_b = 1'b0;
      if (k < 8)  chk_seg("late_old", 8'hFF, 8'hFF, 8'h99);
      else        chk_seg("late_a42", 8'hFF, 8'h99, 8'hA4);
    end

    // ---- reset 3 cycles into conversion of 0x63: 99 must never appear
    grant_a_value(8'h63);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin chk1("mid_gnt_a", gnt_a, 1'b1); req_a = 1'b0; end
      chk_seg("mid_old", 8'hFF, 8'h99, 8'hA4);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_gnt_a", gnt_a, 1'b0);
    chk1("mid_rst_gnt_b", gnt_b, 1'b0);
    chk8("mid_rst_disp", displays, 8'hFE);
    chk8("mid_rst_seg", segmentos, 8'hC0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk1("post_rst_busy", busy, 1'b0);
      chk_seg("post_rst", 8'hFF, 8'hFF, 8'hC0);
    end

    // ---- leading-zero blanking: 0x00 then 0x0A
    grant_a_value(8'h00);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k == 0) begin chk1("zero_gnt_a", gnt_a, 1'b1); req_a = 1'b0; end
      if (k == 18) chk1("zero_busy", busy, 1'b0);
      if (k >= 8) chk_seg("zero", 8'hFF, 8'hFF, 8'hC0);
    end
    grant_a_value(8'h0A);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin chk1("ten_gnt_a", gnt_a, 1'b1); req_a = 1'b0; end
      if (k == 7) chk_seg("ten_old", 8'hFF, 8'hFF, 8'hC0);
      if (k >= 8) chk_seg("ten", 8'hFF, 8'hF9, 8'hC0);
      if (k == 17) chk1("ten_busy_hi", busy, 1'b1);
      if (k == 18) chk1("ten_busy_lo", busy, 1'b0);
    end

    // ---- report
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
